mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's unified instruction/data memory.
- Serves the requests the control FSM issues during its fetch, load-read and store-write states.
- Inserts a configurable number of wait states and returns a one-cycle ready pulse, so the control FSM can stall until the memory completes.
- Sits between the datapath's memory address/data muxes and the storage array.

Parameters:
- WIDTH, 16, data word width in bits.
- ADDR_W, 16, address width in bits (word addressed).
- DEPTH, 256, number of implemented words; legal addresses are 0..DEPTH-1.
- LATENCY, 2, wait-state cycles between request acceptance and response (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  request strobe from the control FSM; held until ready.
- we  input  1  1 = write (store), 0 = read (fetch or load).
- addr  input  ADDR_W  word address.
- wdata  input  WIDTH  store data.
- ready  output  1  one-cycle completion pulse.
- rdata  output  WIDTH  read data; valid while ready=1, otherwise held.
- err  output  1  pulses with ready when addr >= DEPTH.
- busy  output  1  high from acceptance until the ready cycle, inclusive.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ready=0, rdata=0, err=0, busy=0, wait counter=0. The storage array is not reset.
- State machine: IDLE, WAIT, RESP (shared encoding).
- IDLE:
  - On req=1, capture addr, we and wdata into internal registers.
  - Load the counter with LATENCY.
  - Go to WAIT if LATENCY>0, otherwise go to RESP.
  - busy goes high the cycle after acceptance.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESP.
  - Changes on req/addr/we/wdata are ignored because captured values are used.
- RESP:
  - ready=1 for exactly one cycle.
  - Reads: rdata = mem[captured addr].
  - Writes: mem[captured addr] <= captured wdata at the end of this cycle; rdata is unchanged.
  - Next state is always IDLE.
- Latency: ready asserts LATENCY+1 cycles after the acceptance edge. With LATENCY=0, ready asserts on the cycle immediately after acceptance.
- Back-to-back transactions:
  - req=1 in the first IDLE cycle after RESP starts a new transaction. This corresponds to the control FSM advancing from a memory-read state to the next fetch.
  - req still high in the RESP cycle itself is not a new request.
- Out of range (captured addr >= DEPTH):
  - Normal latency applies.
  - In RESP: ready=1, err=1, rdata=0, and the write is suppressed.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Reset during WAIT or RESP: return to IDLE immediately, ready=0, pending write discarded, array contents elsewhere untouched.
- req=0 in IDLE: stay in IDLE, all pulses low.
- X on addr/we/wdata while req=0 or outside IDLE: no effect.

Decomposition:
- Shared CPU package:
  - state encoding (RSP_IDLE, RSP_WAIT, RSP_RESP) as 2-bit constants;
  - WIDTH/ADDR_W defaults shared with the datapath;
  - opcode constants stay where they are.
- One natural sub-module: mem_array, a single-port synchronous-write, combinational-read storage of DEPTH x WIDTH. The responder wraps it with the FSM, counter and capture registers.

Test Plan:
- Reset with LATENCY=2 → ready=0, rdata=0, busy=0. Then req=1, we=0, addr=0 for one cycle (mem[0]=16'hA5F0 preloaded) → busy=1 for 3 cycles, ready=1 and rdata=16'hA5F0 exactly 3 cycles after acceptance.
- Write then read: req/we=1, addr=5, wdata=16'h1234 until ready; next IDLE cycle req, we=0, addr=5 → second ready returns 16'h1234, err=0.
- LATENCY=0 build: req on cycle N → ready on cycle N+1. Four back-to-back reads of addresses 0..3 complete in 8 cycles with correct data.
- Out of range: addr=300 with DEPTH=256, write 16'hFFFF → ready=1, err=1, rdata=0. A subsequent read of addr 300%256=44 returns the unchanged prior value.
- Reset asserted (reset=0) in WAIT of a write to addr 7 → ready never pulses, mem[7] unchanged. After release, a read of addr 7 returns the old value.
- Inputs toggled during WAIT (addr 9→10, we 0→1) → response uses the captured addr 9 as a read, and mem[10] is unchanged.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared CPU package: responder state encoding and datapath width defaults.
package mem_responder_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned CNT_W      = 4;

  typedef logic [1:0] rsp_state_t;

  localparam rsp_state_t RSP_IDLE = 2'd0;
  localparam rsp_state_t RSP_WAIT = 2'd1;
  localparam rsp_state_t RSP_RESP = 2'd2;

  // Index width for a storage of the given depth; never zero.
  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port DEPTH x WIDTH storage: synchronous write, combinational read, no reset.
module mem_responder_mem_array #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: captures a request, inserts LATENCY wait states, then pulses ready
// for one cycle while reading or writing the storage array at the captured address.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic              ready,
  output logic [WIDTH-1:0]  rdata,
  output logic              err,
  output logic              busy
);

  localparam int unsigned IDX_W = idx_w(DEPTH);

  rsp_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic [WIDTH-1:0]  wdata_reg;
  logic [WIDTH-1:0]  rdata_reg, rdata_next;
  logic              accept;
  logic              oor;
  logic              arr_we;
  logic [WIDTH-1:0]  arr_rdata;

  assign accept = (state_reg == RSP_IDLE) && req;
  assign oor    = (32'(addr_reg) >= DEPTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RSP_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Counter, capture registers and held read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg   <= '0;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
      if (accept) begin
        addr_reg  <= addr;
        we_reg    <= we;
        wdata_reg <= wdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RSP_IDLE: begin
        if (req) begin
          cnt_next   = CNT_W'(LATENCY);
          state_next = (LATENCY == 0) ? RSP_RESP : RSP_WAIT;
        end
      end
      RSP_WAIT: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = RSP_RESP;
        end
      end
      RSP_RESP: state_next = RSP_IDLE;
      default:  state_next = RSP_IDLE;
    endcase
  end

  // Outputs decode from the state register only, so reset clears them at once
  // and also drops any pending write enable.
  always_comb begin
    ready      = 1'b0;
    err        = 1'b0;
    busy       = (state_reg != RSP_IDLE);
    arr_we     = 1'b0;
    rdata_next = rdata_reg;
    if (state_reg == RSP_RESP) begin
      ready = 1'b1;
      err   = oor;
      if (oor) begin
        rdata_next = '0;
      end else if (we_reg) begin
        arr_we = 1'b1;
      end else begin
        rdata_next = arr_rdata;
      end
    end
  end

  assign rdata = rdata_next;

  mem_responder_mem_array #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_mem_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (addr_reg[IDX_W-1:0]),
    .wdata(wdata_reg),
    .rdata(arr_rdata)
  );

endmodule
